// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS multi-cycle controller
//   opcode / function / REGIMM-rt constants, state enum,
//   alu_control, pc_control, reg_data and md_op encodings, decode class struct
package mips_pkg;

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e, OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2b;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR    = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MFLO = 6'h12, FN_MULT  = 6'h18, FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV  = 6'h1a, FN_DIVU = 6'h1b, FN_ADD   = 6'h20, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2a, FN_SLTU = 6'h2b;

  // REGIMM rt field
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0, ST_EXEC1 = 3'd1, ST_EXEC2 = 3'd2, ST_MD_WAIT = 3'd3, ST_HALT = 3'd4
  } state_t;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
    ALU_LUI, ALU_EQ, ALU_NE, ALU_LEZ, ALU_GTZ, ALU_LTZ, ALU_GEZ, ALU_MFHI, ALU_MFLO
  } alu_op_t;

  localparam logic [1:0] PC_PLUS4 = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10, PC_JREG = 2'b11;
  // RD_LINK with reg_src = 0 tells the datapath to write r31
  localparam logic [1:0] RD_MEM = 2'b00, RD_LINK = 2'b01, RD_ALU = 2'b10, RD_HILO = 2'b11;
  localparam logic [1:0] MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11;

  typedef struct packed {
    logic load;
    logic store;
    logic st_byte;
    logic st_half;
    logic muldiv;
    logic link;
    logic link_rd;   // JALR: link goes to rd rather than r31
    logic branch;
    logic cmp_rt;    // BEQ/BNE compare against rt, not zero
    logic jump;
    logic jreg;
    logic alu_reg;
    logic alu_imm;
    logic mfhilo;
  } instr_class_t;

endpackage

// File: rtl/mips_instr_class.sv
// rtl/mips_instr_class.sv - combinational opcode/function classification
//   in  instruction[31:0]  instruction register contents
//   out cls                instruction class flags
//   out alu_op             ALU operation for this instruction
module mips_instr_class
  import mips_pkg::*;
(
  input  logic [31:0]  instruction,
  output instr_class_t cls,
  output alu_op_t      alu_op
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic       unused_bits;

  assign op          = instruction[31:26];
  assign rt          = instruction[20:16];
  assign fn          = instruction[5:0];
  assign unused_bits = ^{instruction[25:21], instruction[15:6]};

  always_comb begin
    cls    = '0;
    alu_op = ALU_ADDU;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL:  begin cls.alu_reg = 1'b1; alu_op = ALU_SLL;  end
          FN_SRL:  begin cls.alu_reg = 1'b1; alu_op = ALU_SRL;  end
          FN_SRA:  begin cls.alu_reg = 1'b1; alu_op = ALU_SRA;  end
          FN_SLLV: begin cls.alu_reg = 1'b1; alu_op = ALU_SLLV; end
          FN_SRLV: begin cls.alu_reg = 1'b1; alu_op = ALU_SRLV; end
          FN_SRAV: begin cls.alu_reg = 1'b1; alu_op = ALU_SRAV; end
          FN_ADD:  begin cls.alu_reg = 1'b1; alu_op = ALU_ADD;  end
          FN_ADDU: begin cls.alu_reg = 1'b1; alu_op = ALU_ADDU; end
          FN_SUB:  begin cls.alu_reg = 1'b1; alu_op = ALU_SUB;  end
          FN_SUBU: begin cls.alu_reg = 1'b1; alu_op = ALU_SUBU; end
          FN_AND:  begin cls.alu_reg = 1'b1; alu_op = ALU_AND;  end
          FN_OR:   begin cls.alu_reg = 1'b1; alu_op = ALU_OR;   end
          FN_XOR:  begin cls.alu_reg = 1'b1; alu_op = ALU_XOR;  end
          FN_NOR:  begin cls.alu_reg = 1'b1; alu_op = ALU_NOR;  end
          FN_SLT:  begin cls.alu_reg = 1'b1; alu_op = ALU_SLT;  end
          FN_SLTU: begin cls.alu_reg = 1'b1; alu_op = ALU_SLTU; end
          FN_JR:   cls.jreg = 1'b1;
          FN_JALR: begin cls.jreg = 1'b1; cls.link = 1'b1; cls.link_rd = 1'b1; end
          FN_MFHI: begin cls.mfhilo = 1'b1; alu_op = ALU_MFHI; end
          FN_MFLO: begin cls.mfhilo = 1'b1; alu_op = ALU_MFLO; end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls.muldiv = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   begin cls.branch = 1'b1; alu_op = ALU_LTZ; end
          RT_BGEZ:   begin cls.branch = 1'b1; alu_op = ALU_GEZ; end
          RT_BLTZAL: begin cls.branch = 1'b1; cls.link = 1'b1; alu_op = ALU_LTZ; end
          RT_BGEZAL: begin cls.branch = 1'b1; cls.link = 1'b1; alu_op = ALU_GEZ; end
          default: ;
        endcase
      end
      OP_J:     cls.jump = 1'b1;
      OP_JAL:   begin cls.jump = 1'b1; cls.link = 1'b1; end
      OP_BEQ:   begin cls.branch = 1'b1; cls.cmp_rt = 1'b1; alu_op = ALU_EQ; end
      OP_BNE:   begin cls.branch = 1'b1; cls.cmp_rt = 1'b1; alu_op = ALU_NE; end
      OP_BLEZ:  begin cls.branch = 1'b1; alu_op = ALU_LEZ; end
      OP_BGTZ:  begin cls.branch = 1'b1; alu_op = ALU_GTZ; end
      OP_ADDI:  begin cls.alu_imm = 1'b1; alu_op = ALU_ADD;  end
      OP_ADDIU: begin cls.alu_imm = 1'b1; alu_op = ALU_ADDU; end
      OP_SLTI:  begin cls.alu_imm = 1'b1; alu_op = ALU_SLT;  end
      OP_SLTIU: begin cls.alu_imm = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:  begin cls.alu_imm = 1'b1; alu_op = ALU_AND;  end
      OP_ORI:   begin cls.alu_imm = 1'b1; alu_op = ALU_OR;   end
      OP_XORI:  begin cls.alu_imm = 1'b1; alu_op = ALU_XOR;  end
      OP_LUI:   begin cls.alu_imm = 1'b1; alu_op = ALU_LUI;  end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: cls.load = 1'b1;
      OP_SB:    begin cls.store = 1'b1; cls.st_byte = 1'b1; end
      OP_SH:    begin cls.store = 1'b1; cls.st_half = 1'b1; end
      OP_SW:    cls.store = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// rtl/mips_control_unit.sv - multi-cycle MIPS sequencer and decoder
//   in  clk, reset_n (async active-low), instruction, pc, addr_lo, branch,
//       waitrequest (bus stall), md_done (mul/div result ready)
//   out active, state, ir_en, mem_read, mem_write, mem_src, byte_en,
//       reg_write, reg_data, reg_src, alu_src, alu_control, pc_control,
//       pc_en, md_start, md_op
module mips_control_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR  = 32'h0000_0000,
  parameter bit          MULDIV_EN  = 1'b1,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic [1:0]  addr_lo,
  input  logic        branch,
  input  logic        waitrequest,
  input  logic        md_done,
  output logic        active,
  output logic [2:0]  state,
  output logic        ir_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_src,
  output logic [3:0]  byte_en,
  output logic        reg_write,
  output logic [1:0]  reg_data,
  output logic        reg_src,
  output logic        alu_src,
  output logic [4:0]  alu_control,
  output logic [1:0]  pc_control,
  output logic        pc_en,
  output logic        md_start,
  output logic [1:0]  md_op
);

  // the counter is 7 bits, so a larger timeout is clipped to its ceiling
  localparam logic [7:0] MD_LIMIT = (MD_TIMEOUT > 127) ? 8'd127 : 8'(MD_TIMEOUT);

  state_t       state_q, state_d;
  logic [6:0]   md_cnt_q, md_cnt_d;
  instr_class_t cls;
  alu_op_t      alu_op;

  mips_instr_class u_class (
    .instruction (instruction),
    .cls         (cls),
    .alu_op      (alu_op)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_FETCH;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign state  = state_q;
  assign active = (state_q != ST_HALT);

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    ir_en       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_src     = 1'b0;
    byte_en     = 4'b0000;
    reg_write   = 1'b0;
    reg_data    = RD_ALU;
    reg_src     = 1'b0;
    alu_src     = 1'b0;
    alu_control = alu_op;
    pc_control  = PC_PLUS4;
    pc_en       = 1'b0;
    md_start    = 1'b0;
    md_op       = instruction[1:0];

    case (state_q)
      ST_FETCH: begin
        if (pc == HALT_ADDR) begin
          state_d = ST_HALT;
        end else begin
          mem_read = 1'b1;
          mem_src  = 1'b1;
          byte_en  = 4'b1111;
          if (!waitrequest) begin
            ir_en   = 1'b1;
            state_d = ST_EXEC1;
          end
        end
      end

      ST_EXEC1: begin
        alu_src = cls.alu_reg | cls.cmp_rt;
        reg_src = cls.alu_reg | cls.mfhilo | cls.link_rd;
        if (cls.load) begin
          mem_read = 1'b1;
          byte_en  = 4'b1111;
          if (!waitrequest) state_d = ST_EXEC2;
        end else if (cls.store) begin
          mem_write = 1'b1;
          if (cls.st_byte)      byte_en = 4'b0001 << addr_lo;
          else if (cls.st_half) byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
          else                  byte_en = 4'b1111;
          if (!waitrequest) begin
            pc_en   = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (cls.muldiv && MULDIV_EN) begin
          md_start = 1'b1;
          md_cnt_d = '0;
          state_d  = ST_MD_WAIT;
        end else begin
          // everything else, including undefined opcodes, retires here
          pc_en   = 1'b1;
          state_d = ST_FETCH;
          if (cls.branch)    pc_control = branch ? PC_BRANCH : PC_PLUS4;
          else if (cls.jump) pc_control = PC_JUMP;
          else if (cls.jreg) pc_control = PC_JREG;
          if (cls.link) begin
            reg_write = 1'b1;
            reg_data  = RD_LINK;
          end else if (cls.mfhilo) begin
            reg_write = 1'b1;
            reg_data  = RD_HILO;
          end else if (cls.alu_reg || cls.alu_imm) begin
            reg_write = 1'b1;
          end
        end
      end

      ST_EXEC2: begin
        reg_write = 1'b1;
        reg_data  = RD_MEM;
        pc_en     = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_MD_WAIT: begin
        if (md_done) begin
          pc_en   = 1'b1;
          state_d = ST_FETCH;
        end else if ((MD_LIMIT != 8'd0) && (({1'b0, md_cnt_q} + 8'd1) >= MD_LIMIT)) begin
          state_d = ST_HALT;
        end else if (md_cnt_q != 7'h7f) begin
          md_cnt_d = md_cnt_q + 7'd1;
        end
      end

      ST_HALT: ;

      default: state_d = ST_FETCH;
    endcase

    // state is FETCH during reset, so strobes must be masked explicitly
    if (!reset_n) begin
      ir_en     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
      md_start  = 1'b0;
    end
  end

endmodule
